// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types for the instruction/data memory port arbiter
package riscv_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

  // Byte enables for one 32-bit word; fetches always read whole words.
  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first winner select with a fetch starvation guard
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic sel_if,
  output logic sel_d
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));
  assign sel_if  = grant_en & if_req & (~d_req | starved);
  assign sel_d   = grant_en & d_req & ~sel_if;

  // Counts data grants that overtook a waiting fetch; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (sel_if || !if_req) begin
        starve_cnt <= '0;
      end else if (sel_d && !starved) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t      state, state_n;
  owner_t          owner;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [BW-1:0]   lat_be;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [TW-1:0]   tmo_cnt;
  logic            sel_if, sel_d, grant_en;
  logic            busy, mem_done, tmo_hit, resp_if, resp_d;

  // Response pulses are registered, so grants wait until the pulse has left the port.
  assign grant_en = ~rst & (state == IDLE) & ~if_rvalid & ~d_rvalid;
  assign busy     = (state == REQ) || (state == WAIT);
  assign mem_done = ((state == REQ) && mem_gnt && mem_rvalid) || ((state == WAIT) && mem_rvalid);
  assign tmo_hit  = busy && (tmo_cnt == TW'(TIMEOUT - 1));
  assign resp_if  = (state == RESP) && (owner == OWN_IF);
  assign resp_d   = (state == RESP) && (owner == OWN_D);

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .sel_if   (sel_if),
    .sel_d    (sel_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    if_gnt    = sel_if;
    d_gnt     = sel_d;
    mem_req   = (state == REQ);
    mem_we    = lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_be    = lat_be;
    unique case (state)
      IDLE: if (sel_if || sel_d) state_n = REQ;
      REQ: begin
        if (mem_done || tmo_hit) state_n = RESP;
        else if (mem_gnt)        state_n = WAIT;
      end
      WAIT:    if (mem_done || tmo_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if (sel_if || sel_d) begin
        owner     <= sel_d ? OWN_D : OWN_IF;
        lat_we    <= sel_d & d_we;
        lat_addr  <= sel_d ? d_addr : if_addr;
        lat_wdata <= sel_d ? d_wdata : '0;
        lat_be    <= sel_d ? d_be : {(DW/32){BE_FULL}};
        rdata_q   <= '0;
        err_q     <= 1'b0;
        tmo_cnt   <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (mem_done) begin
          rdata_q <= lat_we ? '0 : mem_rdata;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if_rvalid <= resp_if;
      if_rdata  <= resp_if ? rdata_q : '0;
      if_err    <= resp_if & err_q;
      d_rvalid  <= resp_d;
      d_rdata   <= resp_d ? rdata_q : '0;
      d_err     <= resp_d & err_q;
    end
  end

endmodule
